relu_maxpool_stream: RTL and testbench
======================================

// Module: relu_maxpool_stream
// PURPOSE
//  Downstream neighbour of the bias-add stage: consumes SIZE packed signed 8-bit lanes per beat,
//  applies ReLU per lane, then max-pools over POOL consecutive accepted beats (temporal window).
//  Emits one pooled vector per window over a valid/ready stream toward the next conv/FC layer.
//  Partial windows are closed early by in_last (end of row/frame).
// PARAMETERS
//  SIZE   -1  lanes per beat; must be overridden (>=1)
//  POOL    2  beats per pooling window (>=1); POOL=1 is ReLU-only passthrough
// PORTS
//  clock      in   1        single clock, rising edge
//  reset      in   1        asynchronous, active-low; all state cleared while low
//  in_data    in   8*SIZE   lane i = in_data[8i+7:8i], signed two's complement
//  in_valid   in   1        in_data/in_last valid
//  in_last    in   1        beat closes current window regardless of count
//  in_ready   out  1        block can accept a beat this cycle
//  out_data   out  8*SIZE   pooled lanes, each in 0..127 (unsigned-valued, MSB always 0)
//  out_valid  out  1        out_data/out_last valid
//  out_last   out  1        window was closed by in_last
//  out_ready  in   1        downstream accepts
// BEHAVIOUR
//  - Reset (reset=0): out_valid=0, out_last=0, out_data=0, window count=0, all lane maxima=0.
//    Async assert mid-window discards the partial window; no output produced for it.
//  - Accept: beat taken when in_valid && in_ready. in_ready = !out_valid || out_ready
//    (combinational from out_ready; output register is the only buffer).
//  - ReLU: r = in[7] ? 8'd0 : in. Max register init 0; 0 is a valid identity since r>=0.
//  - Per accepted beat: max_i <= max(max_i, r_i) (unsigned 7-bit compare suffices);
//    cnt <= cnt+1, cnt width = $clog2(POOL+1).
//  - Close: accepted beat with cnt==POOL-1 OR in_last=1. On that edge:
//    out_data <= lanewise max(max_i, r_i) (includes closing beat), out_valid<=1,
//    out_last<=in_last, max_i<=0, cnt<=0. Latency: out_valid rises the cycle after
//    the closing beat is accepted.
//  - Output held stable while out_valid && !out_ready. Pop (out_valid&&out_ready)
//    clears out_valid unless a new close occurs the same cycle, in which case the
//    register reloads and out_valid stays 1: full throughput, one window per POOL beats.
//  - in_last on first beat of window: output is that beat's ReLU alone.
//  - in_last when cnt==POOL-1: single close, out_last=1 (not two outputs).
//  - in_valid=0 cycles: no state change; windows span idle gaps.
//  - No arithmetic overflow possible: max of values in 0..127 stays in 0..127.
//  - State: two-state control {IDLE/ACCUM via cnt, OUT_FULL via out_valid}; no other FSM.
// STRUCTURE
//  - Shared package (cnn_pkg): DATA_W=8 constant, lane slice helper, clog2 function if
//    not native; pooling window encoding shared with the pool-address generator.
//  - One sub-module: relu_max_lane (one per lane via generate): ReLU + running max
//    register + clear; top holds cnt, close logic, output register and handshake.
// TESTING
//  1 SIZE=2,POOL=2: beats {lane1,lane0}={-5,10},{20,3}, out_ready=1 -> one output {20,10},
//    out_last=0, out_valid one cycle after beat 2.
//  2 All-negative window {-128,-1},{-7,-2} -> output {0,0}.
//  3 POOL=4, in_last on 2nd beat {5,9},{6,1} -> output {6,9}, out_last=1; next window
//    starts clean (following {1,1}x4 -> {1,1}).
//  4 Backpressure: out_ready=0 with output pending -> in_ready=0, out_data stable, no beat
//    lost; raise out_ready -> pop and accept same cycle.
//  5 Continuous in_valid=1, out_ready=1, POOL=2, 100 random beats -> 50 outputs match
//    reference model, no bubbles beyond initial latency.
//  6 Drive reset low after 1 beat of a POOL=2 window -> out_valid=0 immediately; after
//    release, beats {3,4},{1,2} -> {3,4} (pre-reset beat not included).

Source files
------------

// File: rtl/relu_maxpool_stream_pkg.sv
// Shared CNN stream constants and lane helpers for the ReLU + temporal max-pool stage.
package relu_maxpool_stream_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] lane_t;

  // Why a pooling window was closed; shared with the pool-address generator.
  typedef enum logic [1:0] {
    CLOSE_NONE  = 2'd0,
    CLOSE_COUNT = 2'd1,
    CLOSE_LAST  = 2'd2
  } close_e;

  function automatic lane_t relu8(input lane_t x);
    return x[DATA_W-1] ? '0 : x;
  endfunction

  // Both operands are already ReLU'd, so an unsigned compare is exact.
  function automatic lane_t lane_max(input lane_t a, input lane_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/relu_maxpool_stream_if.sv
// Valid/ready lane-vector stream with a window-closing last flag.
interface relu_maxpool_stream_if
  import relu_maxpool_stream_pkg::*;
#(
    parameter int SIZE = 1
);
    logic [SIZE-1:0][DATA_W-1:0] data;
    logic                        valid;
    logic                        last;
    logic                        ready;

    modport master(output data, output valid, output last, input ready);
    modport slave(input data, input valid, input last, output ready);
endinterface

// File: rtl/relu_maxpool_stream_lane.sv
// One lane: ReLU on the incoming byte and a running max register cleared on window close.
module relu_max_lane
  import relu_maxpool_stream_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  lane_t din_i,
    input  logic  acc_i,
    input  logic  clr_i,
    output lane_t pool_o
);
    lane_t max_q, max_d, relu_v;

    // pool_o already folds in the current beat so the top can capture it on close.
    always_comb begin
        relu_v = relu8(din_i);
        pool_o = lane_max(max_q, relu_v);
        max_d  = max_q;
        if (clr_i)      max_d = '0;
        else if (acc_i) max_d = pool_o;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) max_q <= '0;
        else         max_q <= max_d;
    end
endmodule

// File: rtl/relu_maxpool_stream.sv
// ReLU per lane, then max-pool over POOL accepted beats (or until in_last); one output register.
module relu_maxpool_stream
  import relu_maxpool_stream_pkg::*;
#(
    parameter int SIZE = -1,
    parameter int POOL = 2
)(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    relu_maxpool_stream_if.slave    in_if,
    relu_maxpool_stream_if.master   out_if
);
    localparam int CNT_W = $clog2(POOL + 1);

    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [SIZE-1:0][DATA_W-1:0]  out_data_q, out_data_d;
    logic [SIZE-1:0][DATA_W-1:0]  pooled;
    logic                         out_valid_q, out_valid_d;
    logic                         out_last_q, out_last_d;
    logic                         acc, close;
    close_e                       reason;

    // The output register is the only buffer, so ready passes straight through.
    assign in_if.ready = !out_valid_q || out_if.ready;
    assign acc         = in_if.valid && in_if.ready;

    always_comb begin
        reason = CLOSE_NONE;
        if (acc && in_if.last)                          reason = CLOSE_LAST;
        else if (acc && cnt_q == CNT_W'(POOL - 1))      reason = CLOSE_COUNT;
    end
    assign close = (reason != CLOSE_NONE);

    for (genvar g = 0; g < SIZE; g++) begin : g_lane
        relu_max_lane u_lane (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .din_i  (in_if.data[g]),
            .acc_i  (acc),
            .clr_i  (close),
            .pool_o (pooled[g])
        );
    end

    always_comb begin
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (close) begin
            cnt_d       = '0;
            out_data_d  = pooled;
            out_valid_d = 1'b1;
            out_last_d  = (reason == CLOSE_LAST);
        end else begin
            if (acc)           cnt_d       = cnt_q + CNT_W'(1);
            if (out_if.ready)  out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_if.data  = out_data_q;
    assign out_if.valid = out_valid_q;
    assign out_if.last  = out_last_q;
endmodule

// File: tb/tb_relu_maxpool_stream.sv
// Directed bench for relu_maxpool_stream: POOL=2 and POOL=4 instances, SIZE=2.
module tb_relu_maxpool_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    relu_maxpool_stream_if #(.SIZE(2)) in2 ();
    relu_maxpool_stream_if #(.SIZE(2)) out2 ();
    relu_maxpool_stream_if #(.SIZE(2)) in4 ();
    relu_maxpool_stream_if #(.SIZE(2)) out4 ();

    relu_maxpool_stream #(.SIZE(2), .POOL(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .in_if(in2), .out_if(out2));
    relu_maxpool_stream #(.SIZE(2), .POOL(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .in_if(in4), .out_if(out4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat2(input logic [15:0] d, input logic last);
        in2.data  = d;
        in2.last  = last;
        in2.valid = 1'b1;
        step();
        in2.valid = 1'b0;
        in2.last  = 1'b0;
    endtask

    task automatic beat4(input logic [15:0] d, input logic last);
        in4.data  = d;
        in4.last  = last;
        in4.valid = 1'b1;
        step();
        in4.valid = 1'b0;
        in4.last  = 1'b0;
    endtask

    function automatic logic [7:0] ref_relu(input logic [7:0] x);
        return ($signed(x) < 0) ? 8'd0 : x;
    endfunction

    function automatic logic [15:0] ref_pool2(input logic [15:0] a, input logic [15:0] b);
        logic [7:0] l0, l1;
        l0 = (ref_relu(a[7:0])  > ref_relu(b[7:0]))  ? ref_relu(a[7:0])  : ref_relu(b[7:0]);
        l1 = (ref_relu(a[15:8]) > ref_relu(b[15:8])) ? ref_relu(a[15:8]) : ref_relu(b[15:8]);
        return {l1, l0};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] prev, cur;
        int          n_out;
        in2.valid = 0; in2.last = 0; in2.data = '0; out2.ready = 1;
        in4.valid = 0; in4.last = 0; in4.data = '0; out4.ready = 1;

        // reset state
        step(); step();
        chk("rst_valid", {31'd0, out2.valid}, 32'd0);
        chk("rst_data",  {16'd0, out2.data},  32'd0);
        chk("rst_last",  {31'd0, out4.last},  32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_ready", {31'd0, in2.ready}, 32'd1);

        // 1: basic POOL=2 window, {-5,10},{20,3} -> {20,10}
        beat2(16'hFB0A, 1'b0);
        chk("t1_no_early", {31'd0, out2.valid}, 32'd0);
        beat2(16'h1403, 1'b0);
        chk("t1_valid", {31'd0, out2.valid}, 32'd1);
        chk("t1_data",  {16'd0, out2.data},  32'h140A);
        chk("t1_last",  {31'd0, out2.last},  32'd0);
        step();
        chk("t1_pop", {31'd0, out2.valid}, 32'd0);

        // 2: all-negative window -> zeros
        beat2(16'h80FF, 1'b0);
        beat2(16'hF9FE, 1'b0);
        chk("t2_valid", {31'd0, out2.valid}, 32'd1);
        chk("t2_data",  {16'd0, out2.data},  32'h0000);
        step();

        // 3: POOL=4 closed early by in_last, then a clean full window
        beat4(16'h0509, 1'b0);
        beat4(16'h0601, 1'b1);
        chk("t3_valid", {31'd0, out4.valid}, 32'd1);
        chk("t3_data",  {16'd0, out4.data},  32'h0609);
        chk("t3_last",  {31'd0, out4.last},  32'd1);
        for (int i = 0; i < 3; i++) beat4(16'h0101, 1'b0);
        chk("t3_mid", {31'd0, out4.valid}, 32'd0);
        beat4(16'h0101, 1'b0);
        chk("t3b_valid", {31'd0, out4.valid}, 32'd1);
        chk("t3b_data",  {16'd0, out4.data},  32'h0101);
        chk("t3b_last",  {31'd0, out4.last},  32'd0);
        step();

        // 4: backpressure holds output and blocks input
        out2.ready = 1'b0;
        beat2(16'h0702, 1'b0);
        beat2(16'h0308, 1'b0);
        chk("t4_valid", {31'd0, out2.valid}, 32'd1);
        chk("t4_data",  {16'd0, out2.data},  32'h0708);
        in2.data = 16'h0909; in2.valid = 1'b1;
        #1;
        chk("t4_blocked", {31'd0, in2.ready}, 32'd0);
        step(); step();
        chk("t4_hold_v", {31'd0, out2.valid}, 32'd1);
        chk("t4_hold_d", {16'd0, out2.data},  32'h0708);
        out2.ready = 1'b1;
        #1;
        chk("t4_ready", {31'd0, in2.ready}, 32'd1);
        step();
        in2.valid = 1'b0;
        chk("t4_popped", {31'd0, out2.valid}, 32'd0);
        beat2(16'h0101, 1'b0);
        chk("t4_kept_v", {31'd0, out2.valid}, 32'd1);
        chk("t4_kept_d", {16'd0, out2.data},  32'h0909);
        step();

        // 5: 100 back-to-back random beats, one output every second beat
        n_out = 0;
        prev  = '0;
        in2.valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            cur = 16'($urandom);
            in2.data = cur;
            step();
            chk("t5_valid", {31'd0, out2.valid}, {31'd0, (k % 2) == 1});
            if (k % 2 == 1) begin
                chk("t5_data", {16'd0, out2.data}, {16'd0, ref_pool2(prev, cur)});
                if (out2.valid) n_out++;
            end
            prev = cur;
        end
        in2.valid = 1'b0;
        chk("t5_count", n_out, 32'd50);
        step();

        // 6: async reset mid-window (dut2) and with output pending (dut4)
        out4.ready = 1'b0;
        in2.data = 16'h3C32; in2.valid = 1'b1;
        in4.data = 16'h0707; in4.valid = 1'b1; in4.last = 1'b1;
        step();
        in2.valid = 1'b0; in4.valid = 1'b0; in4.last = 1'b0;
        chk("t6_pending", {31'd0, out4.valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_v2", {31'd0, out2.valid}, 32'd0);
        chk("t6_rst_v4", {31'd0, out4.valid}, 32'd0);
        chk("t6_rst_d4", {16'd0, out4.data},  32'h0000);
        #2 rst_n = 1'b1;
        out4.ready = 1'b1;
        beat2(16'h0304, 1'b0);
        chk("t6_no_early", {31'd0, out2.valid}, 32'd0);
        beat2(16'h0102, 1'b0);
        chk("t6_valid", {31'd0, out2.valid}, 32'd1);
        chk("t6_data",  {16'd0, out2.data},  32'h0304);
        step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
